ifetch_mem: RTL and testbench

Instruction-side memory responder for the fetch stage. It samples the fetch PC and serves it from a direct-mapped instruction cache, or on a miss assembles the word from the byte-wide RAM port over four reads. Each completed word is signalled by toggling the 2-bit `ok` code, which the fetch stage edge-detects. The block sits between the fetch stage and the RAM arbiter; the load/store unit owns the RAM whenever `stl` is high and this block is idle.

---
 rtl/ifetch_mem.sv | 130 +++++++++++++
 tb/tb_ifetch_mem.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_mem.sv
// Fetch-side memory responder: direct-mapped I-cache in front of a
// byte-wide RAM port, signalling each completed word by toggling ok.
module ifetch_mem #(
  parameter int ENTRIES = 128,
  parameter int ADDR_W  = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        stl,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_req,
  output logic        busy,
  output logic [1:0]  ok,
  output logic [31:0] dt,
  output logic [7:0]  rom_rn,
  output logic        cache_hit
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = ADDR_W - IDX - 2;

  typedef enum logic [2:0] {
    IDLE, M0, M1, M2, M3, M4
  } state_t;

  state_t state, state_n;

  logic [31:0]        fpc;
  logic [7:0]         rom_q;
  logic [31:0]        line_q [ENTRIES];
  logic [TW-1:0]      tag_q  [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  logic [IDX-1:0] pidx, fidx;
  logic [TW-1:0]  ptag, ftag;
  logic           hit;
  logic [1:0]     ok_n;
  logic           unused_pc_lo;

  assign pidx = pc[IDX+1:2];
  assign ptag = pc[ADDR_W-1:IDX+2];
  assign fidx = fpc[IDX+1:2];
  assign ftag = fpc[ADDR_W-1:IDX+2];
  assign hit  = valid_q[pidx] && (tag_q[pidx] == ptag);
  assign ok_n = (ok == 2'd1) ? 2'd2 : 2'd1;
  assign unused_pc_lo = ^pc[1:0];

  assign busy   = (state != IDLE);
  assign rom_rn = (state == M4) ? mem_din : rom_q;

  always_comb begin
    state_n = state;
    mem_a   = 32'd0;
    mem_req = 1'b0;
    unique case (state)
      IDLE: if (!stl) state_n = hit ? IDLE : M0;
      M0: begin
        mem_a   = fpc;
        mem_req = 1'b1;
        state_n = M1;
      end
      M1: begin
        mem_a   = fpc + 32'd1;
        mem_req = 1'b1;
        state_n = M2;
      end
      M2: begin
        mem_a   = fpc + 32'd2;
        mem_req = 1'b1;
        state_n = M3;
      end
      M3: begin
        mem_a   = fpc + 32'd3;
        mem_req = 1'b1;
        state_n = M4;
      end
      M4:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fpc       <= 32'd0;
      ok        <= 2'd0;
      dt        <= 32'd0;
      rom_q     <= 8'd0;
      cache_hit <= 1'b0;
      valid_q   <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (!stl) begin
            fpc <= {pc[31:2], 2'b00};
            if (hit) begin
              dt        <= line_q[pidx];
              cache_hit <= 1'b1;
              ok        <= ok_n;
            end
          end
        end
        M1: dt[7:0]  <= mem_din;
        M2: dt[15:8] <= mem_din;
        M3: begin
          // word is announced now; its top byte arrives during M4
          dt[23:16] <= mem_din;
          ok        <= ok_n;
          cache_hit <= 1'b0;
        end
        M4: begin
          rom_q         <= mem_din;
          valid_q[fidx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == M4) begin
      line_q[fidx] <= {mem_din, dt[23:0]};
      tag_q[fidx]  <= ftag;
    end
  end

endmodule

// File: tb/tb_ifetch_mem.sv
// Bench for ifetch_mem: byte RAM model plus an abstract cache model
// predicting hit/miss, latency, word and ok sequence.
module tb_ifetch_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        stl;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        mem_req;
  logic        busy;
  logic [1:0]  ok;
  logic [31:0] dt;
  logic [7:0]  rom_rn;
  logic        cache_hit;

  ifetch_mem #(.ENTRIES(128), .ADDR_W(17)) dut (
    .clk(clk), .rst(rst), .pc(pc), .stl(stl), .mem_din(mem_din),
    .mem_a(mem_a), .mem_req(mem_req), .busy(busy), .ok(ok),
    .dt(dt), .rom_rn(rom_rn), .cache_hit(cache_hit)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [4096];
  always @(posedge clk) mem_din <= ram[mem_a[11:0]];

  int         n_checks = 0;
  int         n_fail = 0;
  logic       m_valid [128];
  int         m_tag [128];
  logic [1:0] exp_ok;

  function automatic logic [31:0] word_at(input int a);
    return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
  endfunction

  function automatic bit model_hit(input int a);
    int i;
    i = (a >> 2) % 128;
    return m_valid[i] && (m_tag[i] == (a >> 9));
  endfunction

  function automatic void model_fill(input int a);
    int i;
    i = (a >> 2) % 128;
    m_valid[i] = 1'b1;
    m_tag[i] = a >> 9;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    exp_ok = 2'd0;
  endfunction

  function automatic logic [1:0] next_ok(input logic [1:0] o);
    return (o == 2'd1) ? 2'd2 : 2'd1;
  endfunction

  // Presents one pc in IDLE and reports what the DUT did; lat = 0 on timeout.
  task automatic fetch(input int a, output int lat,
                       output logic [31:0] tr_a [4],
                       output logic [3:0] tr_rq,
                       output logic [7:0] rom_m4,
                       output logic busy_end);
    logic [1:0] o0;
    o0 = ok;
    lat = 0;
    rom_m4 = 8'h00;
    tr_rq = 4'h0;
    for (int k = 0; k < 4; k++) tr_a[k] = 32'hx;
    pc = a;
    stl = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      stl = 1'b1;
      if (n <= 4) begin
        tr_a[n-1] = mem_a;
        tr_rq[n-1] = mem_req;
      end
      if (ok !== o0) begin
        lat = n;
        rom_m4 = rom_rn;
        break;
      end
    end
    if (lat > 1) begin
      @(posedge clk);
      @(negedge clk);
    end
    busy_end = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stl = 1'b1;
    pc = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ok !== 2'd0) begin
      n_fail++; $display("FAIL reset_ok: got %0d want 0", ok);
    end
    n_checks++;
    if (dt !== 32'd0) begin
      n_fail++; $display("FAIL reset_dt: got %h want 0", dt);
    end
    n_checks++;
    if ({rom_rn, cache_hit, mem_req, busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_flags: rom %h hit %b req %b busy %b want 0",
               rom_rn, cache_hit, mem_req, busy);
    end
    n_checks++;
    if (mem_a !== 32'd0) begin
      n_fail++; $display("FAIL reset_mem_a: got %h want 0", mem_a);
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_cold_miss();
    int lat;
    logic [31:0] tr [4];
    logic [3:0] rq;
    logic [7:0] r4;
    logic be;
    fetch(0, lat, tr, rq, r4, be);
    exp_ok = next_ok(exp_ok);
    model_fill(0);
    n_checks++;
    if (lat !== 5) begin
      n_fail++; $display("FAIL cold_latency: got %0d want 5", lat);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (tr[k] !== k || rq[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL cold_mem_a%0d: got %h req %b want %h req 1",
                 k, tr[k], rq[k], k);
      end
    end
    n_checks++;
    if (dt[23:0] !== 24'h000513 || r4 !== 8'h00) begin
      n_fail++;
      $display("FAIL cold_word: got %h_%h want 00_000513", r4, dt[23:0]);
    end
    n_checks++;
    if (ok !== 2'd1 || cache_hit !== 1'b0 || be !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_status: ok %0d hit %b busy %b want 1 0 0",
               ok, cache_hit, be);
    end
  endtask

  task automatic test_hit();
    int lat;
    logic [31:0] tr [4];
    logic [3:0] rq;
    logic [7:0] r4;
    logic be;
    fetch(0, lat, tr, rq, r4, be);
    exp_ok = next_ok(exp_ok);
    n_checks++;
    if (lat !== 1) begin
      n_fail++; $display("FAIL hit_latency: got %0d want 1", lat);
    end
    n_checks++;
    if (dt !== 32'h00000513 || cache_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_word: got %h hit %b want 00000513 1",
               dt, cache_hit);
    end
    n_checks++;
    if (ok !== 2'd2 || rq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_status: ok %0d req %b want 2 0", ok, rq[0]);
    end
  endtask

  task automatic test_conflict();
    int lat;
    logic [31:0] tr [4];
    logic [3:0] rq;
    logic [7:0] r4;
    logic be;
    int seq [3] = '{'h000, 'h200, 'h000};
    logic [1:0] oks [3];
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int s = 0; s < 3; s++) begin
      fetch(seq[s], lat, tr, rq, r4, be);
      oks[s] = ok;
      n_checks++;
      if (lat !== 5 || cache_hit !== 1'b0) begin
        n_fail++;
        $display("FAIL conflict_miss%0d: lat %0d hit %b want 5 0",
                 s, lat, cache_hit);
      end
      n_checks++;
      if ({r4, dt[23:0]} !== word_at(seq[s])) begin
        n_fail++;
        $display("FAIL conflict_word%0d: got %h want %h",
                 s, {r4, dt[23:0]}, word_at(seq[s]));
      end
    end
    exp_ok = 2'd1;
    model_fill(0);
    n_checks++;
    if (oks[0] !== 2'd1 || oks[1] !== 2'd2 || oks[2] !== 2'd1) begin
      n_fail++;
      $display("FAIL conflict_ok_seq: got %0d %0d %0d want 1 2 1",
               oks[0], oks[1], oks[2]);
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [31:0] tr [4];
    logic [3:0] rq;
    logic [7:0] r4;
    logic be;
    pc = 32'd4;
    stl = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b0 || ok !== exp_ok || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: req %b ok %0d busy %b want 0 %0d 0",
                 c, mem_req, ok, busy, exp_ok);
      end
    end
    fetch(4, lat, tr, rq, r4, be);
    exp_ok = next_ok(exp_ok);
    model_fill(4);
    n_checks++;
    if (lat !== 5 || tr[0] !== 32'd4 || tr[3] !== 32'd7) begin
      n_fail++;
      $display("FAIL stall_release: lat %0d a0 %h a3 %h want 5 4 7",
               lat, tr[0], tr[3]);
    end
    n_checks++;
    if ({r4, dt[23:0]} !== word_at(4) || ok !== exp_ok) begin
      n_fail++;
      $display("FAIL stall_word: got %h ok %0d want %h %0d",
               {r4, dt[23:0]}, ok, word_at(4), exp_ok);
    end
  endtask

  task automatic test_reset_mid_miss();
    int lat;
    logic [31:0] tr [4];
    logic [3:0] rq;
    logic [7:0] r4;
    logic be;
    pc = 32'h40;
    stl = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    stl = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    n_checks++;
    if (ok !== 2'd0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: ok %0d busy %b req %b want 0 0 0",
               ok, busy, mem_req);
    end
    fetch('h40, lat, tr, rq, r4, be);
    exp_ok = next_ok(exp_ok);
    model_fill('h40);
    n_checks++;
    if (lat !== 5 || {r4, dt[23:0]} !== word_at('h40) || ok !== 2'd1) begin
      n_fail++;
      $display("FAIL midreset_refetch: lat %0d word %h ok %0d want 5 %h 1",
               lat, {r4, dt[23:0]}, ok, word_at('h40));
    end
  endtask

  task automatic test_random();
    int lat, a, want_lat;
    bit h;
    logic [31:0] tr [4];
    logic [3:0] rq;
    logic [7:0] r4;
    logic be;
    logic [31:0] got;
    int pool [8] = '{'h000, 'h004, 'h008, 'h200, 'h204, 'h400, 'h040, 'h600};
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1023) * 4;
      else a = pool[$urandom_range(0, 7)];
      h = model_hit(a);
      want_lat = h ? 1 : 5;
      fetch(a, lat, tr, rq, r4, be);
      exp_ok = next_ok(exp_ok);
      if (!h) model_fill(a);
      got = h ? dt : {r4, dt[23:0]};
      n_checks++;
      if (lat !== want_lat || cache_hit !== h || ok !== exp_ok) begin
        n_fail++;
        $display("FAIL rand%0d_%h: lat %0d hit %b ok %0d want %0d %b %0d",
                 it, a, lat, cache_hit, ok, want_lat, h, exp_ok);
      end
      n_checks++;
      if (got !== word_at(a) || be !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_word_%h: got %h busy %b want %h 0",
                 it, a, got, be, word_at(a));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    stl = 1'b1;
    pc = 32'd0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
    ram['h200] = 8'h93; ram['h201] = 8'h00;
    ram['h202] = 8'h10; ram['h203] = 8'h00;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_stall();
    test_reset_mid_miss();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
